// File: rtl/aes_pkg.sv
// Shared AES types, forward S-box table and byte-position helpers.
// Used by the SubBytes/ShiftRows, MixColumns and AddRoundKey stages.
package aes_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned STATE_BYTES = 16;
  localparam int unsigned STATE_W     = BYTE_W * STATE_BYTES;

  typedef logic [BYTE_W-1:0] aes_byte_t;
  // Element 15 is byte 0 so the packed vector matches in_data[127-8i -: 8].
  typedef aes_byte_t [STATE_BYTES-1:0] aes_state_t;

  typedef struct packed {
    aes_state_t data;
    logic       last;
  } aes_blk_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_OUT  = 2'd2
  } ssr_state_e;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [1:0] byte_row(input logic [3:0] idx);
    return idx[1:0];
  endfunction

  function automatic logic [1:0] byte_col(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  // Source byte for ShiftRows: row r rotates left by r columns.
  function automatic logic [3:0] shift_rows_src(input logic [3:0] idx);
    logic [1:0] row;
    logic [1:0] col;
    row = byte_row(idx);
    col = byte_col(idx);
    return {2'(col + row), row};
  endfunction

  function automatic aes_byte_t get_byte(input aes_state_t s, input logic [3:0] idx);
    return s[4'd15 - idx];
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int unsigned i = 0; i < STATE_BYTES; i++) begin
      r[4'(STATE_BYTES - 1 - i)] = get_byte(s, shift_rows_src(4'(i)));
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single forward AES S-box lookup, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] out_byte_c
);

  assign out_byte_c = SBOX[in_byte];

endmodule

// File: rtl/aes_sub_shift_rows.sv
// Iterative SubBytes + ShiftRows front-end with time-shared S-boxes.
// A block takes STATE_BYTES/BYTES_PER_CYCLE lookup cycles, then is held until consumed.
module aes_sub_shift_rows
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned NUM_STEPS = STATE_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  ssr_state_e        state_q;
  ssr_state_e        next_state;
  logic [STEP_W-1:0] step_q;
  aes_blk_t          work_q;
  aes_state_t        sub_q;
  aes_state_t        out_data_q;
  logic              out_last_q;
  logic              out_valid_q;

  logic              accept_c;
  logic              finish_c;
  logic [3:0]        base_c;
  aes_byte_t         lane_in_c  [BYTES_PER_CYCLE];
  aes_byte_t         lane_out_c [BYTES_PER_CYCLE];
  aes_state_t        sub_next_c;

  // Reset wins over a same-cycle handshake, so ready is gated by rst.
  assign in_ready = (state_q == ST_IDLE) && !rst;

  assign base_c = 4'(32'(step_q) * BYTES_PER_CYCLE);

  always_comb begin : lane_select
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      lane_in_c[j] = work_q.data[4'(STATE_BYTES - 1 - 32'(base_c) - j)];
    end
  end

  for (genvar g = 0; g < int'(BYTES_PER_CYCLE); g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte    (lane_in_c[g]),
      .out_byte_c (lane_out_c[g])
    );
  end

  // Merge this step's lookups into the substituted state.
  always_comb begin : lane_merge
    sub_next_c = sub_q;
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      sub_next_c[4'(STATE_BYTES - 1 - 32'(base_c) - j)] = lane_out_c[j];
    end
  end

  always_comb begin : fsm_next
    next_state = state_q;
    accept_c   = 1'b0;
    finish_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c   = 1'b1;
          next_state = ST_SUB;
        end
      end
      ST_SUB: begin
        if (step_q == LAST_STEP) begin
          finish_c   = 1'b1;
          next_state = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      work_q      <= '0;
      sub_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= next_state;
      out_valid_q <= (next_state == ST_OUT);
      if (accept_c) begin
        work_q.data <= in_data;
        work_q.last <= in_last;
        step_q      <= '0;
      end else if (state_q == ST_SUB) begin
        step_q <= step_q + 1'b1;
        sub_q  <= sub_next_c;
      end
      // Output captured on the final lookup so it is ready the next cycle.
      if (finish_c) begin
        out_data_q <= shift_rows(sub_next_c);
        out_last_q <= work_q.last;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_sub_shift_rows.sv
// Bench for aes_sub_shift_rows at BYTES_PER_CYCLE = 4, 1 and 16.
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_sub_shift_rows;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic         in_last;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [2:0]   out_last;
  logic [127:0] out_data [3];

  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;
  int           cyc     = 0;
  int           acc_q [$];
  logic [127:0] out_q [$];
  logic [7:0]   sbox_tab [256];
  int           lat_tab [3] = '{5, 17, 2};

  typedef struct {
    string        name;
    logic [127:0] d;
    logic         l;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [3];

  aes_sub_shift_rows #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  aes_sub_shift_rows #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  aes_sub_shift_rows #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_last(out_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid[0] && in_ready[0]) acc_q.push_back(cyc);
    if (out_valid[0] && out_ready[0]) out_q.push_back(out_data[0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Substitute into a [row][col] grid, then read each row rotated left by its index.
  function automatic logic [127:0] ref_round(input logic [127:0] d);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) m[i % 4][i / 4] = sbox_tab[d[127 - 8*i -: 8]];
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127 - 8*(r + 4*c) -: 8] = m[r][(c + r) % 4];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic accept(input int idx, input logic [127:0] d, input logic l);
    int n;
    n = 0;
    in_data       = d;
    in_last       = l;
    in_valid[idx] = 1'b1;
    while (in_ready[idx] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (in_ready[idx] !== 1'b1) check("accept_timeout", 128'(in_ready[idx]), 128'(1));
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_valid(input int idx, output int n);
    n = 1;
    while (out_valid[idx] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_block(input int idx, input logic [127:0] d, input logic l,
                           input logic [127:0] exp, input string name);
    int lat;
    accept(idx, d, l);
    wait_valid(idx, lat);
    check({name, "_lat"}, 128'(lat), 128'(lat_tab[idx]));
    check({name, "_data"}, out_data[idx], exp);
    check({name, "_last"}, 128'(out_last[idx]), 128'(l));
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
  endtask

  initial begin
    int           lat;
    int           n;
    logic [127:0] da;
    logic [127:0] db;
    logic [127:0] bp_exp;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    in_last   = 1'b0;
    build_sbox();

    vecs[0] = '{"zero",  {16{8'h00}}, 1'b0, {16{8'h63}}};
    vecs[1] = '{"fips",  128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                         128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[2] = '{"all53", {16{8'h53}}, 1'b1, {16{8'hed}}};

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(3'b000));
    check("rst_out_valid", 128'(out_valid), 128'(3'b000));
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(3'b111));
    check("idle_out_valid", 128'(out_valid), 128'(3'b000));
    check("idle_out_data", out_data[0], 128'h0);
    check("idle_out_last", 128'(out_last), 128'(3'b000));

    for (int i = 0; i < 3; i++) run_block(0, vecs[i].d, vecs[i].l, vecs[i].exp, vecs[i].name);
    run_block(1, vecs[1].d, 1'b0, vecs[1].exp, "fips_b1");
    run_block(2, vecs[1].d, 1'b1, vecs[1].exp, "fips_b16");

    // Backpressure: output held and input blocked for 10 cycles
    bp_exp = {16{8'hed}};
    accept(0, {16{8'h53}}, 1'b1);
    wait_valid(0, lat);
    check("bp_lat", 128'(lat), 128'(5));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_data_%0d", k), out_data[0], bp_exp);
      check($sformatf("bp_hold_%0d", k), 128'({out_valid[0], out_last[0], in_ready[0]}), 128'(3'b110));
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    check("bp_release_in_ready", 128'(in_ready[0]), 128'(0));
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_after_in_ready", 128'(in_ready[0]), 128'(1));
    check("bp_after_out_valid", 128'(out_valid[0]), 128'(0));

    // Back-to-back with out_ready held high
    acc_q.delete();
    out_q.delete();
    da = rand128();
    db = rand128();
    out_ready[0] = 1'b1;
    in_data      = da;
    in_valid[0]  = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
    in_data = db;
    while (acc_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    in_valid[0] = 1'b0;
    while (out_q.size() < 2 && n < 150) begin @(negedge clk); n++; end
    out_ready[0] = 1'b0;
    check("b2b_accepts", 128'(acc_q.size()), 128'(2));
    check("b2b_outputs", 128'(out_q.size()), 128'(2));
    if (acc_q.size() == 2) check("b2b_gap", 128'(acc_q[1] - acc_q[0]), 128'(6));
    if (out_q.size() == 2) begin
      check("b2b_first", out_q[0], ref_round(da));
      check("b2b_second", out_q[1], ref_round(db));
    end
    @(negedge clk);

    // Reset during the second SUB cycle discards the block
    accept(0, rand128(), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_in_ready", 128'(in_ready[0]), 128'(1));
    check("rstmid_out_valid", 128'(out_valid[0]), 128'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rstmid_quiet_%0d", k), 128'(out_valid), 128'(3'b000));
    end
    da = rand128();
    run_block(0, da, 1'b0, ref_round(da), "rstmid_next");

    // Random blocks against the reference model
    for (int k = 0; k < 6; k++) begin
      da = rand128();
      run_block(0, da, 1'($urandom_range(0, 1)), ref_round(da), $sformatf("rnd4_%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      da = rand128();
      run_block(1, da, 1'($urandom_range(0, 1)), ref_round(da), $sformatf("rnd1_%0d", k));
      da = rand128();
      run_block(2, da, 1'($urandom_range(0, 1)), ref_round(da), $sformatf("rnd16_%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
